top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top.sv | 342 ++++++++++++++++++++++++++++++++++
 tb/tb_top.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/top.sv
// ---------------------------------------------------------------------------
// top -- I2C master and I2C slave sharing one open-drain SDA/SCL bus.
//
// The master runs one single-byte transaction per enable request (address
// phase, then one write byte or one read byte, then STOP). The slave answers
// at SLAVE_ADDR, keeps one 8-bit data register, and can stretch SCL after
// every ACK bit it drives.
//
// Optional feature macro: CLOCK_STRETCH_EN
//   defined   : the slave holds SCL low for clock_stretch_delay clk cycles
//               beyond the master's own low half-period after each slave ACK.
//   undefined : the slave never drives SCL; clock_stretch_delay is ignored.
//   The master always reads SCL back and freezes its bit timer while the
//   line is held low by someone else.
//
// Parameters
//   SLAVE_ADDR  7-bit address of the internal slave (default 7'h2A)
//   CLK_DIV     clk cycles per SCL half-period (default 2, must be >= 2 so
//               SDA can move strictly inside the SCL low phase)
//
// Ports
//   clk                  system clock, rising edge
//   rst                  asynchronous active-high reset
//   addr[6:0]            target address, latched at transaction start
//   data_in[7:0]         write byte, latched at transaction start
//   enable               transaction request, sampled only in IDLE
//   rw                   0 = write, 1 = read, latched at transaction start
//   clock_stretch_delay  slave SCL hold time per stretch, in clk cycles
//   data_out[7:0]        last byte read by the master
//   ready                high while the master is IDLE
//   i2c_sda, i2c_scl     open-drain bus (driven 0 or Z only)
// ---------------------------------------------------------------------------
module top #(
    parameter logic [6:0] SLAVE_ADDR = 7'h2A,
    parameter int         CLK_DIV    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] addr,
    input  logic [7:0] data_in,
    input  logic       enable,
    input  logic       rw,
    input  logic [7:0] clock_stretch_delay,
    output logic [7:0] data_out,
    output logic       ready,
    inout  wire        i2c_sda,
    inout  wire        i2c_scl
);

    localparam int              CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(CLK_DIV - 1);

    // ------------------------------------------------------------------
    // Open-drain bus. Every on-chip driver only ever pulls low; the line
    // level is the wired-AND of the pull-downs with the pull-up giving 1.
    // sda_line/scl_line are exactly the levels present on the pads.
    // ------------------------------------------------------------------
    logic m_sda_low_reg, m_scl_low_reg;
    logic s_sda_low_reg, s_scl_low;
    logic sda_line, scl_line;

    assign sda_line = ~(m_sda_low_reg | s_sda_low_reg);
    assign scl_line = ~(m_scl_low_reg | s_scl_low);
    assign i2c_sda  = sda_line ? 1'bz : 1'b0;
    assign i2c_scl  = scl_line ? 1'bz : 1'b0;

    // ------------------------------------------------------------------
    // Master
    // ------------------------------------------------------------------
    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_NACK, STOP
    } m_state_t;

    m_state_t        m_state_reg;
    logic            m_phase_reg;   // 0: SCL low half, 1: SCL released half
    logic [CW-1:0]   m_cnt_reg;
    logic [2:0]      m_bit_reg;
    logic [7:0]      m_shift_reg;
    logic [7:0]      m_data_reg;
    logic            m_rw_reg;
    logic [7:0]      m_rx_reg;
    logic [7:0]      data_out_reg;
    logic            ready_reg;

    assign data_out = data_out_reg;
    assign ready    = ready_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state_reg   <= IDLE;
            m_phase_reg   <= 1'b0;
            m_cnt_reg     <= '0;
            m_bit_reg     <= '0;
            m_shift_reg   <= '0;
            m_data_reg    <= '0;
            m_rw_reg      <= 1'b0;
            m_rx_reg      <= '0;
            m_sda_low_reg <= 1'b0;
            m_scl_low_reg <= 1'b0;
            data_out_reg  <= '0;
            ready_reg     <= 1'b1;
        end else begin
            case (m_state_reg)
                IDLE: begin
                    m_sda_low_reg <= 1'b0;
                    m_scl_low_reg <= 1'b0;
                    if (enable) begin
                        m_shift_reg <= {addr, rw};
                        m_data_reg  <= data_in;
                        m_rw_reg    <= rw;
                        ready_reg   <= 1'b0;
                        m_cnt_reg   <= '0;
                        m_state_reg <= START;
                    end
                end

                // SDA falls with SCL still high, then SCL follows after a
                // half-period of hold time.
                START: begin
                    m_sda_low_reg <= 1'b1;
                    if (m_cnt_reg == CNT_LAST) begin
                        m_scl_low_reg <= 1'b1;
                        m_phase_reg   <= 1'b0;
                        m_cnt_reg     <= '0;
                        m_bit_reg     <= 3'd7;
                        m_state_reg   <= ADDR;
                    end else begin
                        m_cnt_reg <= m_cnt_reg + 1'b1;
                    end
                end

                // Shared bit engine for all bit-level states and STOP.
                default: begin
                    if (!m_phase_reg) begin
                        // One cycle into the low half: SCL is already low,
                        // so SDA moves strictly inside the low phase.
                        if (m_cnt_reg == '0) begin
                            case (m_state_reg)
                                ADDR, WR_DATA: m_sda_low_reg <= ~m_shift_reg[7];
                                STOP:          m_sda_low_reg <= 1'b1;
                                default:       m_sda_low_reg <= 1'b0;
                            endcase
                        end
                        if (m_cnt_reg == CNT_LAST) begin
                            m_scl_low_reg <= 1'b0;
                            m_phase_reg   <= 1'b1;
                            m_cnt_reg     <= '0;
                        end else begin
                            m_cnt_reg <= m_cnt_reg + 1'b1;
                        end
                    end else if (scl_line) begin
                        // The high half only counts once the line really
                        // is high, so a slave stretch freezes the timer.
                        if (m_cnt_reg != CNT_LAST) begin
                            m_cnt_reg <= m_cnt_reg + 1'b1;
                        end else begin
                            m_cnt_reg     <= '0;
                            m_phase_reg   <= 1'b0;
                            m_scl_low_reg <= 1'b1;
                            case (m_state_reg)
                                ADDR: begin
                                    m_shift_reg <= {m_shift_reg[6:0], 1'b0};
                                    if (m_bit_reg == 3'd0) m_state_reg <= ADDR_ACK;
                                    else                   m_bit_reg   <= m_bit_reg - 3'd1;
                                end
                                ADDR_ACK: begin
                                    if (!sda_line) begin
                                        m_shift_reg <= m_data_reg;
                                        m_bit_reg   <= 3'd7;
                                        m_state_reg <= m_rw_reg ? RD_DATA : WR_DATA;
                                    end else begin
                                        m_state_reg <= STOP;
                                    end
                                end
                                WR_DATA: begin
                                    m_shift_reg <= {m_shift_reg[6:0], 1'b0};
                                    if (m_bit_reg == 3'd0) m_state_reg <= WR_ACK;
                                    else                   m_bit_reg   <= m_bit_reg - 3'd1;
                                end
                                RD_DATA: begin
                                    m_rx_reg <= {m_rx_reg[6:0], sda_line};
                                    if (m_bit_reg == 3'd0) begin
                                        data_out_reg <= {m_rx_reg[6:0], sda_line};
                                        m_state_reg  <= RD_NACK;
                                    end else begin
                                        m_bit_reg <= m_bit_reg - 3'd1;
                                    end
                                end
                                WR_ACK, RD_NACK: m_state_reg <= STOP;
                                STOP: begin
                                    // SDA rises while SCL stays released.
                                    m_scl_low_reg <= 1'b0;
                                    m_sda_low_reg <= 1'b0;
                                    ready_reg     <= 1'b1;
                                    m_state_reg   <= IDLE;
                                end
                                default: m_state_reg <= IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Slave
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR, S_WR_ACK, S_RD, S_IGNORE
    } s_state_t;

    s_state_t   s_state_reg;
    logic [3:0] s_bit_reg;
    logic [7:0] s_shift_reg;
    logic       s_rw_reg;
    logic [7:0] slave_data_reg;
    logic       sda_prev_reg, scl_prev_reg;

    logic scl_rise, scl_fall, bus_start, bus_stop, stretch_go;

    assign scl_rise   = scl_line & ~scl_prev_reg;
    assign scl_fall   = ~scl_line & scl_prev_reg;
    assign bus_start  = scl_line & scl_prev_reg & sda_prev_reg & ~sda_line;
    assign bus_stop   = scl_line & scl_prev_reg & ~sda_prev_reg & sda_line;
    // The falling edge that closes an ACK bit this slave drove.
    assign stretch_go = scl_fall & ((s_state_reg == S_ADDR_ACK) || (s_state_reg == S_WR_ACK));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_state_reg    <= S_IDLE;
            s_bit_reg      <= '0;
            s_shift_reg    <= '0;
            s_rw_reg       <= 1'b0;
            slave_data_reg <= 8'h00;
            s_sda_low_reg  <= 1'b0;
            sda_prev_reg   <= 1'b1;
            scl_prev_reg   <= 1'b1;
        end else begin
            sda_prev_reg <= sda_line;
            scl_prev_reg <= scl_line;
            if (bus_start) begin
                s_state_reg   <= S_ADDR;
                s_bit_reg     <= '0;
                s_sda_low_reg <= 1'b0;
            end else if (bus_stop) begin
                s_state_reg   <= S_IDLE;
                s_sda_low_reg <= 1'b0;
            end else begin
                case (s_state_reg)
                    S_ADDR: begin
                        if (scl_rise) begin
                            s_shift_reg <= {s_shift_reg[6:0], sda_line};
                            s_bit_reg   <= s_bit_reg + 4'd1;
                        end else if (scl_fall && s_bit_reg == 4'd8) begin
                            if (s_shift_reg[7:1] == SLAVE_ADDR) begin
                                s_rw_reg      <= s_shift_reg[0];
                                s_sda_low_reg <= 1'b1;
                                s_state_reg   <= S_ADDR_ACK;
                            end else begin
                                // Not addressed: stay off the bus until the next START.
                                s_state_reg <= S_IGNORE;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (s_rw_reg) begin
                                s_sda_low_reg <= ~slave_data_reg[7];
                                s_shift_reg   <= {slave_data_reg[6:0], 1'b0};
                                s_bit_reg     <= 4'd1;
                                s_state_reg   <= S_RD;
                            end else begin
                                s_sda_low_reg <= 1'b0;
                                s_bit_reg     <= '0;
                                s_state_reg   <= S_WR;
                            end
                        end
                    end
                    S_WR: begin
                        if (scl_rise) begin
                            s_shift_reg <= {s_shift_reg[6:0], sda_line};
                            s_bit_reg   <= s_bit_reg + 4'd1;
                        end else if (scl_fall && s_bit_reg == 4'd8) begin
                            slave_data_reg <= s_shift_reg;
                            s_sda_low_reg  <= 1'b1;
                            s_state_reg    <= S_WR_ACK;
                        end
                    end
                    S_WR_ACK: begin
                        if (scl_fall) begin
                            s_sda_low_reg <= 1'b0;
                            s_state_reg   <= S_IGNORE;
                        end
                    end
                    S_RD: begin
                        if (scl_fall) begin
                            if (s_bit_reg == 4'd8) begin
                                // Hand SDA to the master for its ACK/NACK bit.
                                s_sda_low_reg <= 1'b0;
                                s_state_reg   <= S_IGNORE;
                            end else begin
                                s_sda_low_reg <= ~s_shift_reg[7];
                                s_shift_reg   <= {s_shift_reg[6:0], 1'b0};
                                s_bit_reg     <= s_bit_reg + 4'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef CLOCK_STRETCH_EN
    // The slave grabs SCL on the cycle it sees the ACK-closing fall and keeps
    // it for the master's own low half-period plus clock_stretch_delay, so
    // the extension seen on the bus is the full delay.
    logic        s_scl_low_reg;
    logic [15:0] stretch_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_scl_low_reg   <= 1'b0;
            stretch_cnt_reg <= '0;
        end else if (s_scl_low_reg) begin
            if (stretch_cnt_reg == '0) s_scl_low_reg   <= 1'b0;
            else                       stretch_cnt_reg <= stretch_cnt_reg - 16'd1;
        end else if (stretch_go && clock_stretch_delay != 8'd0) begin
            s_scl_low_reg   <= 1'b1;
            stretch_cnt_reg <= 16'(clock_stretch_delay) + 16'(CLK_DIV - 1);
        end
    end

    assign s_scl_low = s_scl_low_reg;
`else
    assign s_scl_low = 1'b0;
    logic unused_stretch;
    assign unused_stretch = &{1'b0, clock_stretch_delay, stretch_go};
`endif

endmodule

// File: tb/tb_top.sv
`timescale 1ns/1ps
// Bench for top: randomized transactions against a transaction-level model.
// Stimulus pushes the expected bus transaction into a queue; an I2C bus
// monitor decodes START/bytes/ACKs/STOP from the pads and pops/compares.
module tb_top;
    localparam logic [6:0] SADDR   = 7'h2A;
    localparam int         CLK_DIV = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] addr;
    logic [7:0] data_in;
    logic       enable;
    logic       rw;
    logic [7:0] clock_stretch_delay;
    logic [7:0] data_out;
    logic       ready;
    wire        i2c_sda, i2c_scl;

    pullup (i2c_sda);
    pullup (i2c_scl);

    top #(.SLAVE_ADDR(SADDR), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .enable(enable),
        .rw(rw), .clock_stretch_delay(clock_stretch_delay), .data_out(data_out),
        .ready(ready), .i2c_sda(i2c_sda), .i2c_scl(i2c_scl)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] b0;
        logic       a0;
        int         nbytes;
        logic [7:0] b1;
        logic       a1;
        logic [7:0] dout;
    } txn_t;

    txn_t       exp_q[$];
    logic [7:0] model_reg  = 8'h00;
    logic [7:0] model_dout = 8'h00;
    int         issued     = 0;
    int         txn_seen   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    function automatic void check_ge(input string name, input int act, input int req);
        checks++;
        if (act < req) begin
            errors++;
            $display("FAIL %s: got %0d expected at least %0d", name, act, req);
        end
    endfunction

    // ---------------- bus monitor / scoreboard ----------------
    logic       sda_p = 1'b1, scl_p = 1'b1;
    logic [8:0] bits;
    int         mon_nbits = 0, mon_bytes = 0, low_cnt = 0;
    logic       in_txn = 1'b0, stretch_pending = 1'b0;
    logic [7:0] mb0, mb1;
    logic       ma0, ma1;

    always @(negedge clk) begin
        logic sda, scl;
        txn_t e;
        sda = (i2c_sda !== 1'b0);
        scl = (i2c_scl !== 1'b0);
        if (rst) begin
            in_txn = 1'b0; stretch_pending = 1'b0;
            mon_nbits = 0; mon_bytes = 0; low_cnt = 0;
            sda_p = 1'b1; scl_p = 1'b1;
        end else begin
            if (scl && scl_p && sda_p && !sda) begin
                in_txn = 1'b1; mon_nbits = 0; mon_bytes = 0; stretch_pending = 1'b0;
            end else if (scl && scl_p && !sda_p && sda && in_txn) begin
                in_txn = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_txn: got byte0 %0h expected no transaction", mb0);
                end else begin
                    e = exp_q.pop_front();
                    txn_seen++;
                    check("addr_byte", mb0, e.b0);
                    check("addr_ack", ma0, e.a0);
                    check("byte_count", mon_bytes, e.nbytes);
                    if (e.nbytes == 2) begin
                        check("data_byte", mb1, e.b1);
                        check("data_ack", ma1, e.a1);
                    end
                    check("data_out", data_out, e.dout);
                end
            end else if (scl && !scl_p && in_txn) begin
                if (stretch_pending) begin
`ifdef CLOCK_STRETCH_EN
                    check_ge("stretch_low", low_cnt,
                             (clock_stretch_delay == 0) ? CLK_DIV : int'(clock_stretch_delay) + CLK_DIV);
`else
                    check("no_stretch_low", low_cnt, CLK_DIV);
`endif
                end
                stretch_pending = 1'b0;
                bits = {bits[7:0], sda};
                mon_nbits++;
                if (mon_nbits == 9) begin
                    if (mon_bytes == 0) begin mb0 = bits[8:1]; ma0 = bits[0]; end
                    else                begin mb1 = bits[8:1]; ma1 = bits[0]; end
                    // Slave-driven ACKs: the address ACK, and the data ACK of a write.
                    stretch_pending = !bits[0] && (mon_bytes == 0 || !mb0[0]);
                    mon_bytes++;
                    mon_nbits = 0;
                end
            end
            low_cnt = scl ? 0 : low_cnt + 1;
            sda_p = sda;
            scl_p = scl;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_txn(input logic [6:0] a, input logic r, input logic [7:0] d,
                          input logic [7:0] dly, output int cycles);
        txn_t e;
        logic match;
        match    = (a == SADDR);
        e.b0     = {a, r};
        e.a0     = !match;
        e.nbytes = 1;
        e.b1     = 8'h00;
        e.a1     = 1'b1;
        if (match && !r) begin
            e.nbytes = 2; e.b1 = d; e.a1 = 1'b0; model_reg = d;
        end else if (match && r) begin
            e.nbytes = 2; e.b1 = model_reg; e.a1 = 1'b1; model_dout = model_reg;
        end
        e.dout = model_dout;
        exp_q.push_back(e);
        issued++;

        @(negedge clk);
        addr = a; rw = r; data_in = d; clock_stretch_delay = dly; enable = 1'b1;
        @(negedge clk);
        check("busy_after_start", ready, 1'b0);
        @(negedge clk);
        enable = 1'b0;
        // Values must already be latched; disturb them.
        addr = 7'($urandom); rw = 1'($urandom); data_in = 8'($urandom);
        cycles = 2;
        while (ready !== 1'b1 && cycles < 5000) begin
            @(negedge clk);
            cycles++;
            if (cycles == 20) begin
                enable = 1'b1; addr = 7'($urandom); rw = 1'($urandom);
            end
            if (cycles == 22) enable = 1'b0;
        end
        check("ready_return", ready, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    int c0, c50, cyc, n;

    initial begin
        rst = 1'b1; addr = '0; data_in = '0; enable = 1'b0; rw = 1'b0; clock_stretch_delay = '0;
        repeat (3) @(negedge clk);
        check("rst_data_out", data_out, 8'h00);
        check("rst_sda_released", (i2c_sda !== 1'b0), 1'b1);
        check("rst_scl_released", (i2c_scl !== 1'b0), 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", ready, 1'b1);

        do_txn(SADDR, 1'b0, 8'hAA, 8'd10, cyc);   // write AA
        do_txn(SADDR, 1'b1, 8'h00, 8'd50, cyc);   // read back AA
        do_txn(SADDR, 1'b0, 8'hAA, 8'd1,  cyc);
        do_txn(7'h2B, 1'b0, 8'h11, 8'd10, cyc);   // wrong address write
        do_txn(7'h2B, 1'b1, 8'h00, 8'd10, cyc);   // wrong address read
        do_txn(SADDR, 1'b1, 8'h00, 8'd0,  cyc);   // register untouched

        do_txn(SADDR, 1'b0, 8'h3C, 8'd0,  c0);
        do_txn(SADDR, 1'b0, 8'h3C, 8'd50, c50);
`ifdef CLOCK_STRETCH_EN
        check_ge("stretched_length", c50, c0 + 100);
`else
        check("length_independent_of_delay", c50, c0);
`endif

        for (int i = 0; i < 20; i++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 1) == 0) ? SADDR : 7'($urandom);
            do_txn(a, 1'($urandom), 8'($urandom), 8'($urandom_range(0, 20)), cyc);
        end

        // Reset in the middle of a write data byte.
        @(negedge clk);
        addr = SADDR; rw = 1'b0; data_in = 8'h5A; clock_stretch_delay = 8'd5; enable = 1'b1;
        repeat (2) @(negedge clk);
        enable = 1'b0;
        n = 0;
        while (!(mon_bytes == 1 && mon_nbits >= 3) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reach_wr_data", (n < 2000), 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midop_sda_released", (i2c_sda !== 1'b0), 1'b1);
        check("midop_scl_released", (i2c_scl !== 1'b0), 1'b1);
        check("midop_ready", ready, 1'b1);
        check("midop_data_out", data_out, 8'h00);
        model_reg = 8'h00; model_dout = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_txn(SADDR, 1'b1, 8'h00, 8'd3, cyc);    // register was cleared

        repeat (10) @(negedge clk);
        check("pending_expectations", exp_q.size(), 0);
        check("txn_count", txn_seen, issued);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
